sync_fifo_param: RTL

Parametrised single-clock FIFO, successor to the fixed 16 x 32-bit synchronous FIFO. Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and protected full/empty behaviour. Overflow and underflow are reported as pulses. A compile-time first-word-fall-through mode is available. It is the general-purpose buffering element between producer and consumer logic in the same clock domain.

---
 rtl/sync_fifo_param_if.sv | 33 +++
 rtl/sync_fifo_param.sv | 107 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: producer/consumer side is the
// master, the FIFO itself is the slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr;
  logic [DATA_W-1:0] din;
  logic              rd;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, din, rd,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, din, rd,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              af_reg;
  logic              ae_reg;
  logic              ovf_reg;
  logic              unf_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              dv_reg;

  logic rd_acc;
  logic wr_acc;

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign rd_acc = bus.rd & ~empty_reg;
  assign wr_acc = bus.wr & (~full_reg | bus.rd);

  assign rd_ptr_next = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst)
      mem[wr_ptr_reg] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      af_reg     <= (AF_LEVEL == 0);
      ae_reg     <= 1'b1;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      dout_reg   <= '0;
      dv_reg     <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == FULL_CNT);
      empty_reg  <= (count_next == '0);
      af_reg     <= (count_next >= AF_CNT);
      ae_reg     <= (count_next <= AE_CNT);
      ovf_reg    <= bus.wr & full_reg & ~bus.rd;
      unf_reg    <= bus.rd & empty_reg;
`ifdef SYNC_FIFO_FWFT_EN
      // Prefetch the next head; a write landing on it this cycle is bypassed
      // since the array still holds the stale word at that address.
      if (wr_acc && (wr_ptr_reg == rd_ptr_next))
        dout_reg <= bus.din;
      else
        dout_reg <= mem[rd_ptr_next];
      dv_reg <= (count_next != '0);
`else
      if (rd_acc)
        dout_reg <= mem[rd_ptr_reg];
      dv_reg <= rd_acc;
`endif
    end
  end

  assign bus.dout         = dout_reg;
  assign bus.dout_valid   = dv_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = af_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.count        = count_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = unf_reg;
endmodule
